// File: rtl/fp_div_scheduler_pkg.sv
// Shared types, constants and operand-class helpers for fp_div_scheduler.
package fp_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam int unsigned REM_W   = 25;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  function automatic logic is_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

endpackage

// File: rtl/fp_div_scheduler_arb.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int unsigned j;
  logic        found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[IW'(j)]) begin
        found            = 1'b1;
        grant[IW'(j)]    = 1'b1;
        idx              = IW'(j);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fp_div_scheduler.sv
// Time-shares one iterative FP divider core across NUM_REQ requesters.
// Optional FP_DIV_SPECIAL_BYPASS_EN answers special operands without the core.
module fp_div_scheduler
  import fp_div_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DIV_CYCLES = 250,
  localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_num1,
  input  logic [NUM_REQ*32-1:0] req_num2,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic [REM_W-1:0]      rsp_remainder,
  output logic                  busy,
  output logic                  core_rstn,
  output logic [31:0]           core_num1,
  output logic [31:0]           core_num2,
  input  logic [31:0]           core_result,
  input  logic [REM_W-1:0]      core_remainder
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   ptr_nxt;
  logic [CNT_W-1:0]  count;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]   gidx;
  logic              any;
  logic [31:0]       sel_num1;
  logic [31:0]       sel_num2;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  // Accept is only offered while idle and never while reset is asserted.
  assign req_ready = (state == IDLE && !rst) ? grant : '0;
  assign ptr_nxt   = (32'(gidx) == NUM_REQ - 1) ? '0 : gidx + ID_W'(1);

  always_comb begin
    sel_num1 = '0;
    sel_num2 = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gidx == ID_W'(i)) begin
        sel_num1 = req_num1[32*i +: 32];
        sel_num2 = req_num2[32*i +: 32];
      end
    end
  end

`ifdef FP_DIV_SPECIAL_BYPASS_EN
  logic        sp_hit;
  logic [31:0] sp_res;
  logic        sp_sgn;

  // Classify the granted operands; anything not special goes to the core.
  always_comb begin
    sp_hit = 1'b0;
    sp_res = QNAN;
    sp_sgn = sel_num1[31] ^ sel_num2[31];
    if (is_nan(sel_num1) || is_nan(sel_num2) ||
        (is_zero(sel_num1) && is_zero(sel_num2)) ||
        (is_inf(sel_num1) && is_inf(sel_num2))) begin
      sp_hit = 1'b1;
      sp_res = QNAN;
    end else if (is_zero(sel_num2) || is_inf(sel_num1)) begin
      sp_hit = 1'b1;
      sp_res = {sp_sgn, POS_INF[30:0]};
    end else if (is_inf(sel_num2)) begin
      sp_hit = 1'b1;
      sp_res = {sp_sgn, 31'd0};
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      count         <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_result    <= '0;
      rsp_remainder <= '0;
      busy          <= 1'b0;
      core_rstn     <= 1'b0;
      core_num1     <= '0;
      core_num2     <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          core_num1 <= sel_num1;
          core_num2 <= sel_num2;
          rsp_id    <= gidx;
          ptr       <= ptr_nxt;
          busy      <= 1'b1;
`ifdef FP_DIV_SPECIAL_BYPASS_EN
          if (sp_hit) begin
            rsp_result    <= sp_res;
            rsp_remainder <= '0;
            rsp_valid     <= 1'b1;
            state         <= RESP;
          end else begin
            state <= LOAD;
          end
`else
          state <= LOAD;
`endif
        end
        LOAD: begin
          count     <= CNT_W'(DIV_CYCLES - 1);
          core_rstn <= 1'b1;
          state     <= RUN;
        end
        RUN: begin
          if (count == '0) begin
            rsp_result    <= core_result;
            rsp_remainder <= core_remainder;
            core_rstn     <= 1'b0;
            rsp_valid     <= 1'b1;
            state         <= RESP;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_scheduler.sv
// Directed bench for fp_div_scheduler with a latency-accurate divider core stand-in.
module tb_fp_div_scheduler;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DIV  = 250;
  localparam int unsigned LAT  = DIV + 2;
`ifdef FP_DIV_SPECIAL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_num1;
  logic [NREQ*32-1:0]   req_num2;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic [1:0]           rsp_id;
  logic [31:0]          rsp_result;
  logic [24:0]          rsp_remainder;
  logic                 busy;
  logic                 core_rstn;
  logic [31:0]          core_num1, core_num2, core_result;
  logic [24:0]          core_remainder;

  logic [31:0] a_arr [NREQ];
  logic [31:0] b_arr [NREQ];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int unsigned ccnt = 0;

  fp_div_scheduler #(.NUM_REQ(NREQ), .DIV_CYCLES(DIV)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_num1(req_num1), .req_num2(req_num2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_remainder(rsp_remainder),
    .busy(busy), .core_rstn(core_rstn),
    .core_num1(core_num1), .core_num2(core_num2),
    .core_result(core_result), .core_remainder(core_remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_num1[32*i +: 32] = a_arr[i];
      req_num2[32*i +: 32] = b_arr[i];
    end
  end

  // Core stand-in: known quotient for the reference vector, a fixed mix otherwise.
  function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h414EB852 && b == 32'h4148A3D7) return 32'h3F83E0F8;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  function automatic logic [24:0] ref_r(input logic [31:0] a, input logic [31:0] b);
    return {a[12:0], b[11:0]};
  endfunction

  // Result is garbage until DIV-1 clocks have elapsed with core_rstn high.
  always @(posedge clk) begin
    if (!core_rstn) ccnt <= 0;
    else if (ccnt < DIV) ccnt <= ccnt + 1;
  end
  assign core_result    = (ccnt >= DIV - 1) ? ref_q(core_num1, core_num2) : {16'hBAD0, ccnt[15:0]};
  assign core_remainder = (ccnt >= DIV - 1) ? ref_r(core_num1, core_num2) : {9'h1BA, ccnt[15:0]};

  // Requester rule monitor: a pending request must hold valid and operands.
  logic [NREQ-1:0]    pv = '0, pr = '0;
  logic [NREQ*32-1:0] p1 = '0, p2 = '0;
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pv[i] && !pr[i])
          assert (req_valid[i] && req_num1[32*i +: 32] === p1[32*i +: 32] &&
                  req_num2[32*i +: 32] === p2[32*i +: 32])
          else begin
            miscompares++;
            $error("FAIL req_rule port %0d: valid %b", i, req_valid[i]);
          end
      end
    end
    pv <= req_valid;
    pr <= req_ready;
    p1 <= req_num1;
    p2 <= req_num2;
  end

  always @(negedge clk) begin
    assert (!(rsp_valid && (|req_ready))) else begin
      miscompares++;
      $error("FAIL rsp_req_overlap: rsp_valid %b req_ready %b", rsp_valid, req_ready);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(output logic [NREQ-1:0] g, output int t);
    int n = 0;
    while (req_ready == '0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("grant_seen", 32'(|req_ready), 32'd1);
    g = req_ready;
    t = cyc;
  endtask

  task automatic wait_rsp(output int t);
    int n = 0;
    while (!rsp_valid && n < int'(LAT) + 50) begin
      @(negedge clk);
      n++;
    end
    check("rsp_seen", 32'(rsp_valid), 32'd1);
    t = cyc;
  endtask

  // Assert reset, check outputs asynchronously, release two clocks later.
  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_core_rstn"}, 32'(core_rstn), 32'd0);
    check({tag, "_rsp_result"}, rsp_result, 32'd0);
    check({tag, "_rsp_rem"}, 32'(rsp_remainder), 32'd0);
    check({tag, "_core_num1"}, core_num1, 32'd0);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_one(input int port, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic [24:0] exp_rem,
                         input int lat);
    logic [NREQ-1:0] g;
    int t0, t1;
    a_arr[port] = a;
    b_arr[port] = b;
    req_valid   = NREQ'(1 << port);
    @(negedge clk);
    wait_grant(g, t0);
    check("one_grant", 32'(g), 32'(1 << port));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("one_core_rstn_after_grant", 32'(core_rstn), 32'd0);
    check("one_busy", 32'(busy), 32'd1);
    wait_rsp(t1);
    check("one_latency", 32'(t1 - t0), 32'(lat));
    check("one_rsp_id", 32'(rsp_id), 32'(port));
    check("one_rsp_result", rsp_result, exp_res);
    check("one_rsp_rem", 32'(rsp_remainder), 32'(exp_rem));
    @(negedge clk);
  endtask

  initial begin
    logic [NREQ-1:0] g;
    int t0, tr, t2, t3, nrise;

    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = 32'h40000000 + 32'(i * 32'h00123457);
      b_arr[i] = 32'h3F900000 + 32'(i * 32'h00011111);
    end

    // Reset state with all requests asserted
    req_valid = '1;
    @(negedge clk);
    pulse_reset("por");

    // Single request on port 2 through the core
    run_one(2, 32'h414EB852, 32'h4148A3D7, 32'h3F83E0F8,
            ref_r(32'h414EB852, 32'h4148A3D7), LAT);

    // Round-robin order with all ports held valid
    @(negedge clk);
    pulse_reset("rst2");
    rsp_ready = 1'b1;
    req_valid = '1;
    @(negedge clk);
    tr = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, t0);
      check("rr_grant", 32'(g), 32'(1 << (k % 4)));
      if (k > 0) check("rr_gap", 32'(t0 - tr), 32'd1);
      @(negedge clk);
      wait_rsp(tr);
      check("rr_latency", 32'(tr - t0), 32'(LAT));
      check("rr_id", 32'(rsp_id), 32'(k % 4));
      check("rr_result", rsp_result, ref_q(a_arr[k % 4], b_arr[k % 4]));
      @(negedge clk);
    end

    // Backpressure: response held for 20+ cycles, no new accept
    rsp_ready = 1'b0;
    wait_grant(g, t0);
    check("bp_grant", 32'(g), 32'h2);
    @(negedge clk);
    wait_rsp(tr);
    check("bp_latency", 32'(tr - t0), 32'(LAT));
    repeat (20) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_id", 32'(rsp_id), 32'd1);
      check("bp_result", rsp_result, ref_q(a_arr[1], b_arr[1]));
      check("bp_rem", 32'(rsp_remainder), 32'(ref_r(a_arr[1], b_arr[1])));
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    nrise = cyc;
    rsp_ready = 1'b1;
    wait_grant(g, t0);
    check("bp_resume_cycle", 32'(t0), 32'(nrise + 1));
    check("bp_resume_grant", 32'(g), 32'h4);

    // Abort at RUN count==100, then a port-3 request from the reset pointer
    while (cyc < t0 + 2 + int'(DIV) - 1 - 100) @(negedge clk);
    check("abort_core_rstn", 32'(core_rstn), 32'd1);
    check("abort_busy", 32'(busy), 32'd1);
    pulse_reset("abort");
    check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    run_one(3, 32'h3E800000, 32'h40400000, ref_q(32'h3E800000, 32'h40400000),
            ref_r(32'h3E800000, 32'h40400000), LAT);

    // Special operands: bypass when enabled, core otherwise
    run_one(0, 32'h3F800000, 32'h80000000,
            BYP ? 32'hFF800000 : ref_q(32'h3F800000, 32'h80000000),
            BYP ? 25'd0 : ref_r(32'h3F800000, 32'h80000000), BYP ? 1 : int'(LAT));
    run_one(1, 32'h7FC00001, 32'h3F800000,
            BYP ? 32'h7FC00000 : ref_q(32'h7FC00001, 32'h3F800000),
            BYP ? 25'd0 : ref_r(32'h7FC00001, 32'h3F800000), BYP ? 1 : int'(LAT));
    run_one(2, 32'h00000000, 32'h00000000,
            BYP ? 32'h7FC00000 : ref_q(32'h00000000, 32'h00000000),
            BYP ? 25'd0 : ref_r(32'h00000000, 32'h00000000), BYP ? 1 : int'(LAT));

    // Back-to-back from one requester: accept every DIV+3, one idle cycle
    a_arr[1] = 32'h41200000;
    b_arr[1] = 32'h40A00000;
    req_valid = 4'b0010;
    @(negedge clk);
    wait_grant(g, t0);
    check("b2b_grant", 32'(g), 32'h2);
    @(negedge clk);
    wait_rsp(tr);
    check("b2b_busy_resp", 32'(busy), 32'd1);
    @(negedge clk);
    wait_grant(g, t2);
    check("b2b_period", 32'(t2 - t0), 32'(DIV + 3));
    check("b2b_busy_gap", 32'(busy), 32'd0);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("b2b_busy_load", 32'(busy), 32'd1);
    wait_rsp(t3);
    check("b2b_latency", 32'(t3 - t2), 32'(LAT));
    check("b2b_result", rsp_result, ref_q(32'h41200000, 32'h40A00000));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_div_scheduler.md
Name: fp_div_scheduler

Overview:
Shares one iterative IEEE-754 single-precision divider core (IEEE_divider) between NUM_REQ requesters. Requests are arbitrated round-robin with per-port valid/ready handshakes. The scheduler sequences the core by pulsing its active-low clear (core_rstn), counts the fixed iteration latency, and captures the quotient and remainder. It then returns them, tagged with the requester id, over a single valid/ready response port.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DIV_CYCLES, 250, core cycles from core_rstn release to a stable result (>=1)
ID_W, $clog2(NUM_REQ), localparam width of rsp_id

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_num1  in  NUM_REQ*32  dividends, requester i at [32*i+:32]
req_num2  in  NUM_REQ*32  divisors, same packing
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  ID_W  index of the requester that issued the request
rsp_result  out  32  IEEE-754 quotient
rsp_remainder  out  25  core remainder
busy  out  1  high in any state except IDLE
core_rstn  out  1  core clear, active-low
core_num1  out  32  core dividend
core_num2  out  32  core divisor
core_result  in  32  core quotient
core_remainder  in  25  core remainder

Behaviour:
- Reset (async, any state): state=IDLE, rr pointer=0, all outputs 0 (including core_rstn=0 and req_ready=0), count=0. An in-flight operation is discarded and no response is issued for it.
- States: IDLE, LOAD, RUN, RESP.
- IDLE, arbitration:
  - Grant g is the first i with req_valid[i], searching from ptr upward mod NUM_REQ.
  - req_ready[g]=1 combinationally in IDLE only; the handshake completes in that cycle.
  - On handshake: latch core_num1/num2 and rsp_id=g, set ptr=(g+1) mod NUM_REQ, go to LOAD.
  - No valid requests: stay in IDLE, ptr unchanged.
- LOAD: one cycle with core_rstn=0 and operands stable; count=DIV_CYCLES-1; go to RUN.
- RUN: core_rstn=1; count decrements each cycle. At count==0, capture core_result/core_remainder into rsp_result/rsp_remainder and go to RESP.
- RESP:
  - rsp_valid=1, core_rstn=0.
  - When rsp_ready=1: go to IDLE.
  - When rsp_ready=0: rsp_* hold stable indefinitely.
- Latency: handshake at cycle T gives rsp_valid first high at T+2+DIV_CYCLES. The next grant is possible no earlier than the cycle after the response handshake, so there is one operation in flight at a time.
- core_rstn is high only in RUN. Core operands are held stable from LOAD through the end of RUN.
- Requester rules: req_num1/num2 must remain stable while req_valid=1 and not yet granted, and req_valid must not drop before req_ready. A bench assertion flags any violation.
- rsp_valid and req_ready are never high in the same cycle.

Optional Feature:
Macro FP_DIV_SPECIAL_BYPASS_EN.
- With the macro defined, in IDLE a granted request with special operands goes directly to RESP, skipping the core (rsp_valid at T+1, rsp_remainder=0). Results:
  - Either operand NaN, 0/0, or inf/inf: 0x7FC00000.
  - x/±0 with x nonzero non-NaN: ±inf, sign = sign1 XOR sign2.
  - inf/finite: ±inf, same sign rule.
  - finite/inf: ±0, same sign rule.
  - The round-robin pointer updates normally.
- Without the macro: every request goes through LOAD/RUN and no operand decode logic exists.

Decomposition:
- Package fp_div_pkg contains:
  - state enum typedef
  - QNAN=32'h7FC00000, POS_INF=32'h7F800000
  - REM_W=25
  - functions is_nan, is_inf, is_zero on 32-bit operands
- Sub-module rr_arbiter (parameter N): inputs req, ptr; outputs one-hot grant, grant index, any. It is purely combinational; the scheduler owns ptr.

Test Plan:
- Req 2 only, num1=0x414EB852, num2=0x4148A3D7, real core, DIV_CYCLES=250 -> rsp_id=2, rsp_result=0x3F83E0F8, rsp_valid first high exactly 252 cycles after the handshake.
- After reset, all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0. Each next req_ready arrives the cycle after the previous response handshake.
- rsp_ready held low 20 cycles in RESP -> rsp_valid=1 and rsp_* stable throughout, req_ready=0 while req_valid=4'b1111; acceptance resumes the cycle after rsp_ready rises.
- rst pulsed at RUN count=100 -> all outputs 0 asynchronously, no response for the aborted request. After release, a req on port 3 is granted first (ptr=0 search, only port 3 valid) and completes normally.
- With FP_DIV_SPECIAL_BYPASS_EN: 0x3F800000/0x80000000 -> 0xFF800000 at T+1; 0x7FC00001/0x3F800000 -> 0x7FC00000; 0x00000000/0x00000000 -> 0x7FC00000; core_rstn stays 0. Without the macro, the same stimulus takes T+252.
- Single requester re-asserting immediately, rsp_ready tied high -> a new accept every DIV_CYCLES+3 cycles, busy low for exactly one cycle between operations.
